// File: rtl/axi_w_order_scheduler.sv
// Shares one AXI AW/W master port among NumReq write requesters: round-robin AW
// arbitration, with W beats forwarded in AW-grant order from a circular order queue.
module axi_w_order_scheduler #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned MaxWTxns = 4,
    localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned OccW    = $clog2(MaxWTxns + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       slv_aw_valid_i,
    output logic [NumReq-1:0]       slv_aw_ready_o,
    input  logic [NumReq-1:0][7:0]  slv_aw_len_i,
    output logic                    mst_aw_valid_o,
    input  logic                    mst_aw_ready_i,
    output logic [IdxW-1:0]         aw_sel_o,
    input  logic [NumReq-1:0]       slv_w_valid_i,
    output logic [NumReq-1:0]       slv_w_ready_o,
    output logic                    mst_w_valid_o,
    input  logic                    mst_w_ready_i,
    output logic                    mst_w_last_o,
    output logic [IdxW-1:0]         w_sel_o,
    output logic [OccW-1:0]         w_pending_o
);
    localparam int unsigned PtrW = (MaxWTxns > 1) ? $clog2(MaxWTxns) : 1;

    logic [IdxW-1:0] rr_q, rr_d, lock_sel_q, lock_sel_d, rr_pick;
    logic            lock_q, lock_d, found;
    int unsigned     cand;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] qidx_q [MaxWTxns];
    logic [7:0]      qlen_q [MaxWTxns];
    logic            full, empty, aw_hs, w_hs, pop;
    logic [IdxW-1:0] head_idx;
    logic [7:0]      head_len;

    // First valid requester at or above rr_q, wrapping.
    always_comb begin
        rr_pick = rr_q;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = (int'(rr_q) + i) % NumReq;
            if (!found && slv_aw_valid_i[cand]) begin
                found   = 1'b1;
                rr_pick = IdxW'(cand);
            end
        end
    end

    assign full     = (occ_q == OccW'(MaxWTxns));
    assign empty    = (occ_q == '0);
    assign head_idx = qidx_q[rptr_q];
    assign head_len = qlen_q[rptr_q];

    always_comb begin
        aw_sel_o       = lock_q ? lock_sel_q : rr_pick;
        mst_aw_valid_o = (|slv_aw_valid_i) && !full;
        slv_aw_ready_o = '0;
        if (mst_aw_valid_o) slv_aw_ready_o[aw_sel_o] = mst_aw_ready_i;
        aw_hs          = mst_aw_valid_o && mst_aw_ready_i;

        w_sel_o       = '0;
        mst_w_valid_o = 1'b0;
        mst_w_last_o  = 1'b0;
        slv_w_ready_o = '0;
        if (!empty) begin
            w_sel_o                 = head_idx;
            mst_w_valid_o           = slv_w_valid_i[head_idx];
            mst_w_last_o            = (cnt_q == head_len);
            slv_w_ready_o[head_idx] = mst_w_ready_i;
        end
        w_hs = mst_w_valid_o && mst_w_ready_i;
        pop  = w_hs && mst_w_last_o;
    end

    always_comb begin
        // A pending AW that the master has not yet taken pins the selection.
        lock_d     = mst_aw_valid_o && !mst_aw_ready_i;
        lock_sel_d = lock_d ? aw_sel_o : lock_sel_q;
        rr_d       = rr_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;
        if (aw_hs) begin
            rr_d   = (aw_sel_o == IdxW'(NumReq - 1)) ? '0 : aw_sel_o + 1'b1;
            wptr_d = (wptr_q == PtrW'(MaxWTxns - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxWTxns - 1)) ? '0 : rptr_q + 1'b1;
            cnt_d  = '0;
        end else if (w_hs) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (aw_hs && !pop)      occ_d = occ_q + 1'b1;
        else if (pop && !aw_hs) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
        end
    end

    // Queue payload needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (aw_hs) begin
            qidx_q[wptr_q] <= aw_sel_o;
            qlen_q[wptr_q] <= slv_aw_len_i[aw_sel_o];
        end
    end

    assign w_pending_o = occ_q;
endmodule

// File: tb/tb_axi_w_order_scheduler.sv
// Directed scenarios plus a random phase, every cycle checked against a
// transaction-level model (grant order list, per-burst beat count).
module tb_axi_w_order_scheduler;
    localparam int N  = 2;
    localparam int MW = 2;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     aw_v, aw_rdy_o, w_v, w_rdy_o;
    logic [N-1:0][7:0] aw_len;
    logic             mawv, mawr, mwv, mwr, mwl;
    logic [0:0]       aw_sel, w_sel;
    logic [1:0]       pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_w_order_scheduler #(.NumReq(N), .MaxWTxns(MW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv_aw_valid_i(aw_v), .slv_aw_ready_o(aw_rdy_o), .slv_aw_len_i(aw_len),
        .mst_aw_valid_o(mawv), .mst_aw_ready_i(mawr), .aw_sel_o(aw_sel),
        .slv_w_valid_i(w_v), .slv_w_ready_o(w_rdy_o),
        .mst_w_valid_o(mwv), .mst_w_ready_i(mwr), .mst_w_last_o(mwl),
        .w_sel_o(w_sel), .w_pending_o(pend)
    );

    // Model: grants in order, beats sent in current burst, held AW grant.
    int qidx[$];
    int qlen[$];
    int beats;
    int rr;
    int held;
    int last_hs_req;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(int from, logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(from + k) % N]) return (from + k) % N;
        return from;
    endfunction

    task automatic model_clear();
        qidx.delete(); qlen.delete();
        beats = 0; rr = 0; held = -1; last_hs_req = -1;
    endtask

    task automatic settle();
        #2;
    endtask

    // One clock: check all outputs mid-cycle, then advance model on the edge.
    task automatic cyc();
        bit e_awv, busy, e_last;
        int e_sel, h;
        logic [N-1:0] e_awr, e_wr;
        @(negedge clk);
        e_awv = (|aw_v) && (qidx.size() < MW);
        e_sel = (held >= 0) ? held : pick(rr, aw_v);
        busy  = qidx.size() > 0;
        h     = busy ? qidx[0] : 0;
        e_last = busy && (beats == qlen[0]);
        e_awr = '0;
        if (e_awv) e_awr[e_sel] = mawr;
        e_wr = '0;
        if (busy) e_wr[h] = mwr;
        chk("aw_valid", 32'(mawv), 32'(e_awv));
        chk("aw_ready", 32'(aw_rdy_o), 32'(e_awr));
        if (e_awv) chk("aw_sel", 32'(aw_sel), 32'(e_sel));
        chk("pending", 32'(pend), 32'(qidx.size()));
        chk("w_sel", 32'(w_sel), 32'(h));
        chk("w_valid", 32'(mwv), 32'(busy && w_v[h]));
        chk("w_ready", 32'(w_rdy_o), 32'(e_wr));
        chk("w_last", 32'(mwl), 32'(e_last));
        @(posedge clk);
        last_hs_req = -1;
        if (busy && w_v[h] && mwr) begin
            if (e_last) begin
                void'(qidx.pop_front()); void'(qlen.pop_front()); beats = 0;
            end else beats++;
        end
        if (e_awv && mawr) begin
            qidx.push_back(e_sel); qlen.push_back(int'(aw_len[e_sel]));
            rr = (e_sel + 1) % N; held = -1; last_hs_req = e_sel;
        end else held = e_awv ? e_sel : -1;
        #1;
    endtask

    task automatic idle_in();
        aw_v = '0; w_v = '0; mawr = 1'b0; mwr = 1'b0; aw_len = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_clear();
    endtask

    int es[4] = '{1, 1, 1, 0};
    int el[4] = '{0, 0, 1, 1};
    int rs[4] = '{0, 1, 0, 1};

    initial begin
        idle_in();
        model_clear();
        rst_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        // Reset state with all inputs low.
        settle();
        chk("rst_awv", 32'(mawv), 0);   chk("rst_wv", 32'(mwv), 0);
        chk("rst_last", 32'(mwl), 0);   chk("rst_awr", 32'(aw_rdy_o), 0);
        chk("rst_wr", 32'(w_rdy_o), 0); chk("rst_awsel", 32'(aw_sel), 0);
        chk("rst_wsel", 32'(w_sel), 0); chk("rst_pend", 32'(pend), 0);
        cyc();

        // Round-robin with both requesters always valid; W drains len-0 bursts.
        aw_v = 2'b11; mawr = 1'b1; w_v = 2'b11; mwr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle(); chk("rr_seq", 32'(aw_sel), 32'(rs[k])); cyc();
        end

        // AW stability while master stalls.
        idle_in(); do_reset();
        aw_v = 2'b01;
        settle(); chk("lock0", 32'(aw_sel), 0); cyc();
        aw_v = 2'b11;
        settle(); chk("lock1", 32'(aw_sel), 0); cyc();
        settle(); chk("lock2", 32'(aw_sel), 0); cyc();
        mawr = 1'b1;
        settle(); chk("lock_hs", 32'(aw_sel), 0); cyc();
        aw_v = 2'b10;
        settle(); chk("lock_next", 32'(aw_sel), 1); cyc();

        // W ordering and last generation.
        idle_in(); do_reset();
        aw_v = 2'b10; aw_len[1] = 8'd2; mawr = 1'b1; cyc();
        aw_v = 2'b01; aw_len[0] = 8'd0; cyc();
        aw_v = 2'b00; w_v = 2'b11; mwr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("ord_sel", 32'(w_sel), 32'(es[k]));
            chk("ord_last", 32'(mwl), 32'(el[k]));
            chk("ord_valid", 32'(mwv), 1);
            cyc();
        end
        settle(); chk("ord_empty", 32'(pend), 0); cyc();

        // Queue full blocks AW until a burst completes.
        idle_in(); do_reset();
        aw_v = 2'b11; mawr = 1'b1; cyc(); cyc();
        settle(); chk("full_pend", 32'(pend), 2); chk("full_awv", 32'(mawv), 0); cyc();
        w_v = 2'b11; mwr = 1'b1;
        settle(); chk("full_awv2", 32'(mawv), 0); cyc();
        w_v = 2'b00;
        settle(); chk("refill_awv", 32'(mawv), 1); chk("refill_pend", 32'(pend), 1); cyc();

        // Simultaneous push and pop.
        idle_in(); do_reset();
        aw_v = 2'b01; mawr = 1'b1; cyc();
        aw_v = 2'b10; aw_len[1] = 8'd1; w_v = 2'b11; mwr = 1'b1;
        settle(); chk("pp_pend", 32'(pend), 1); chk("pp_last", 32'(mwl), 1); cyc();
        aw_v = 2'b00;
        settle(); chk("pp_pend2", 32'(pend), 1); chk("pp_wsel", 32'(w_sel), 1); cyc();

        // Mid-burst reset.
        idle_in(); do_reset();
        aw_v = 2'b01; aw_len[0] = 8'd3; mawr = 1'b1; cyc();
        aw_v = 2'b00; w_v = 2'b01; mwr = 1'b1; cyc();
        aw_v = 2'b11; w_v = 2'b11;
        do_reset();
        aw_v = 2'b00;
        settle();
        chk("mrst_wv", 32'(mwv), 0);   chk("mrst_pend", 32'(pend), 0);
        chk("mrst_last", 32'(mwl), 0); chk("mrst_wr", 32'(w_rdy_o), 0);
        idle_in();
        settle();
        chk("mrst_awv", 32'(mawv), 0); chk("mrst_wsel", 32'(w_sel), 0);
        cyc();

        // Random traffic obeying AW valid-hold rules.
        idle_in(); do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            if (last_hs_req >= 0) aw_v[last_hs_req] = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (!aw_v[r] && ($urandom_range(0, 1) == 1)) begin
                    aw_v[r]   = 1'b1;
                    aw_len[r] = 8'($urandom_range(0, 3));
                end
            end
            w_v  = N'($urandom);
            mawr = ($urandom_range(0, 3) != 0);
            mwr  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
